regfile_wb_queue: RTL and testbench

Write-back queue for the 8×16 register file. It buffers register write requests from the pipeline's write-back stage and issues at most one write per cycle on the register file's single write port (`Regwrite`/`WriteReg`/`WriteData`). It also provides a pending-write lookup, so hazard/forwarding logic can see values that are queued but not yet written.

---
 rtl/regfile_wb_pkg.sv | 22 ++
 rtl/regfile_wb_queue_match.sv | 49 ++++
 rtl/regfile_wb_queue.sv | 166 ++++++++++++++++
 tb/tb_regfile_wb_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared definitions for the register-file write-back queue.
//   WBQ_DATA_W / WBQ_ADDR_W / WBQ_DEPTH : default widths and depth
//   wbq_entry_t                         : one queued write {reg_idx, data}
//   wbq_count_t                         : occupancy count for the default depth
// ----------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int WBQ_DATA_W = 16;
    localparam int WBQ_ADDR_W = 3;
    localparam int WBQ_DEPTH  = 4;

    // "reg" is a keyword, so the destination register field is reg_idx.
    typedef struct packed {
        logic [WBQ_ADDR_W-1:0] reg_idx;
        logic [WBQ_DATA_W-1:0] data;
    } wbq_entry_t;

    typedef logic [$clog2(WBQ_DEPTH+1)-1:0] wbq_count_t;

endpackage

// File: rtl/regfile_wb_queue_match.sv
// ----------------------------------------------------------------------------
// wbq_match
// Priority matcher for pending-write lookup. Walks the circular queue from
// the oldest entry (head) to the newest; a later match overrides an earlier
// one, so the newest pending write to lookup_reg wins.
//   entry_reg / entry_data : queue storage (unpacked, DEPTH entries)
//   valid                  : per-entry occupied mask
//   head                   : index of the oldest entry
//   lookup_reg             : register being queried
//   hit / data             : newest match; data is 0 when there is no hit
// ----------------------------------------------------------------------------
module wbq_match
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W
) (
    input  logic [ADDR_W-1:0]          entry_reg  [DEPTH],
    input  logic [DATA_W-1:0]          entry_data [DEPTH],
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [ADDR_W-1:0]          lookup_reg,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx_s;

    // Oldest-to-newest scan; index wraps naturally because DEPTH is a power of two.
    always_comb begin
        hit   = 1'b0;
        data  = {DATA_W{1'b0}};
        idx_s = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head + PTR_W'(i);
            if (valid[idx_s] && (entry_reg[idx_s] == lookup_reg)) begin
                hit  = 1'b1;
                data = entry_data[idx_s];
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// ----------------------------------------------------------------------------
// regfile_wb_queue
// Write-back queue in front of the 8x16 register file's single write port.
// Buffers write-back requests and issues at most one per cycle, strictly in
// arrival order, and exposes a pending-write lookup for hazard/forwarding.
//
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : request handshake (in_ready = !full)
//   in_reg/in_data               : destination register and write data
//   hold                         : suppress issue this cycle, keep contents
//   wr_en/wr_reg/wr_data         : to Regwrite/WriteReg/WriteData
//   lookup_reg                   : register being queried
//   lookup_hit/lookup_data       : newest pending write to lookup_reg (0 on miss)
//   count/empty/full             : occupancy status (registered)
//
// Configuration macro:
//   WBQ_INPUT_BYPASS_EN : when defined, an accepted request on in_* is also
//                         visible to lookup in the cycle it is presented, with
//                         priority over stored entries.
// ----------------------------------------------------------------------------
module regfile_wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           in_reg,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        hold,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_reg,
    output logic [DATA_W-1:0]           wr_data,
    input  logic [ADDR_W-1:0]           lookup_reg,
    output logic                        lookup_hit,
    output logic [DATA_W-1:0]           lookup_data,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        empty,
    output logic                        full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] reg_mem_r  [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              empty_r;
    logic              full_r;

    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              match_hit_s;
    logic [DATA_W-1:0] match_data_s;

    // Handshake and issue. in_ready comes from the registered full flag, so a
    // pop in the same cycle never lets a request fall through a full queue.
    always_comb begin
        push_s = in_valid && !full_r;
        pop_s  = !empty_r && !hold;
    end

    // Occupancy update for the four push/pop combinations.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            2'b11:   count_next_s = count_r;
            2'b00:   count_next_s = count_r;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy, status flags and per-entry valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (push_s) begin
                tail_r          <= tail_r + PTR_W'(1);
                valid_r[tail_r] <= 1'b1;
            end
            if (pop_s) begin
                head_r          <= head_r + PTR_W'(1);
                valid_r[head_r] <= 1'b0;
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == {CNT_W{1'b0}});
            full_r  <= (count_next_s == CNT_W'(DEPTH));
        end
    end

    // Entry payload storage; contents are qualified by valid_r, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            reg_mem_r[tail_r]  <= in_reg;
            data_mem_r[tail_r] <= in_data;
        end
    end

    // Write-port drive: head entry, forced to zero while empty.
    always_comb begin
        wr_en    = pop_s;
        in_ready = !full_r;
        count    = count_r;
        empty    = empty_r;
        full     = full_r;
        if (empty_r) begin
            wr_reg  = {ADDR_W{1'b0}};
            wr_data = {DATA_W{1'b0}};
        end else begin
            wr_reg  = reg_mem_r[head_r];
            wr_data = data_mem_r[head_r];
        end
    end

    wbq_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_match (
        .entry_reg  (reg_mem_r),
        .entry_data (data_mem_r),
        .valid      (valid_r),
        .head       (head_r),
        .lookup_reg (lookup_reg),
        .hit        (match_hit_s),
        .data       (match_data_s)
    );

`ifdef WBQ_INPUT_BYPASS_EN
    // Lookup result: the request being accepted this cycle outranks stored
    // entries. Gated by rst so lookup reads as a miss while reset is held.
    always_comb begin
        if (push_s && !rst && (in_reg == lookup_reg)) begin
            lookup_hit  = 1'b1;
            lookup_data = in_data;
        end else begin
            lookup_hit  = match_hit_s;
            lookup_data = match_data_s;
        end
    end
`else
    // Lookup result: stored entries only.
    always_comb begin
        lookup_hit  = match_hit_s;
        lookup_data = match_data_s;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_queue
// Directed, self-checking bench for regfile_wb_queue (DEPTH=4, 16-bit data).
// Inputs change 1 time unit after a posedge; outputs are checked a further
// time unit later, well away from the next rising edge.
// ----------------------------------------------------------------------------
module tb_regfile_wb_queue;
    import regfile_wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_reg;
    logic [15:0] in_data;
    logic        hold;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;
    logic [2:0]  lookup_reg;
    logic        lookup_hit;
    logic [15:0] lookup_data;
    wbq_count_t  count;
    logic        empty;
    logic        full;

    int checks;
    int failures;

    regfile_wb_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_reg      (in_reg),
        .in_data     (in_data),
        .hold        (hold),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .lookup_reg  (lookup_reg),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_reg = 3'd0; in_data = 16'h0000;
        hold = 1'b0; lookup_reg = 3'd0;
        #2;
        checks++; if (wr_en !== 1'b0)      begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", wr_en); end
        checks++; if (empty !== 1'b1)      begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0)       begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (count !== 3'd0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL reset_lookup_hit got=%0b exp=0", lookup_hit); end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_reg = 3'd3; in_data = 16'h1234; hold = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b1)        begin failures++; $display("FAIL single_wr_en got=%0b exp=1", wr_en); end
        checks++; if (wr_reg !== 3'd3)       begin failures++; $display("FAIL single_wr_reg got=%0d exp=3", wr_reg); end
        checks++; if (wr_data !== 16'h1234)  begin failures++; $display("FAIL single_wr_data got=%h exp=1234", wr_data); end
        checks++; if (count !== 3'd1)        begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        tick();
        checks++; if (empty !== 1'b1)        begin failures++; $display("FAIL single_empty_after got=%0b exp=1", empty); end
        checks++; if (wr_en !== 1'b0)        begin failures++; $display("FAIL single_wr_en_after got=%0b exp=0", wr_en); end
        checks++; if (wr_data !== 16'h0000)  begin failures++; $display("FAIL single_wr_data_empty got=%h exp=0000", wr_data); end
    endtask

    task automatic test_full_hold();
        wbq_entry_t tbl [4];
        tbl[0] = '{reg_idx: 3'd1, data: 16'h1111};
        tbl[1] = '{reg_idx: 3'd2, data: 16'h2222};
        tbl[2] = '{reg_idx: 3'd4, data: 16'h4444};
        tbl[3] = '{reg_idx: 3'd6, data: 16'h6666};
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = tbl[i].reg_idx; in_data = tbl[i].data;
            tick();
        end
        in_reg = 3'd7; in_data = 16'h7777;
        #1;
        checks++; if (full !== 1'b1)     begin failures++; $display("FAIL full_flag got=%0b exp=1", full); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
        checks++; if (wr_en !== 1'b0)    begin failures++; $display("FAIL full_hold_wr_en got=%0b exp=0", wr_en); end
        tick();
        in_valid = 1'b0; lookup_reg = 3'd7;
        #1;
        checks++; if (count !== 3'd4)      begin failures++; $display("FAIL full_drop_count got=%0d exp=4", count); end
        checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL full_drop_lookup got=%0b exp=0", lookup_hit); end
        lookup_reg = 3'd2;
        #1;
        checks++; if (lookup_data !== 16'h2222) begin failures++; $display("FAIL full_lookup_r2 got=%h exp=2222", lookup_data); end
        hold = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_in_ready got=%0b exp=0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL drain_wr_en[%0d] got=%0b exp=1", i, wr_en); end
            checks++; if (wr_reg !== tbl[i].reg_idx || wr_data !== tbl[i].data) begin
                failures++; $display("FAIL drain_entry[%0d] got=%0d/%h exp=%0d/%h", i, wr_reg, wr_data, tbl[i].reg_idx, tbl[i].data);
            end
            tick();
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_lookup_newest();
        hold = 1'b1;
        in_valid = 1'b1; in_reg = 3'd5; in_data = 16'hAAAA;
        tick();
        in_data = 16'hBBBB;
        tick();
        in_valid = 1'b0; lookup_reg = 3'd5;
        #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_data !== 16'hBBBB) begin
            failures++; $display("FAIL lookup_newest got=%0b/%h exp=1/bbbb", lookup_hit, lookup_data);
        end
        lookup_reg = 3'd4;
        #1;
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0000) begin
            failures++; $display("FAIL lookup_miss got=%0b/%h exp=0/0000", lookup_hit, lookup_data);
        end
        lookup_reg = 3'd5; hold = 1'b0;
        tick();
        checks++; if (wr_data !== 16'hBBBB || lookup_hit !== 1'b1 || lookup_data !== 16'hBBBB) begin
            failures++; $display("FAIL lookup_head_pending got=%h/%0b/%h exp=bbbb/1/bbbb", wr_data, lookup_hit, lookup_data);
        end
        tick();
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0000) begin
            failures++; $display("FAIL lookup_after_issue got=%0b/%h exp=0/0000", lookup_hit, lookup_data);
        end
    endtask

    task automatic test_hold_delay();
        hold = 1'b1;
        in_valid = 1'b1; in_reg = 3'd1; in_data = 16'h0101;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (wr_en !== 1'b0 || count !== 3'd1) begin
                failures++; $display("FAIL hold_cycle[%0d] got=%0b/%0d exp=0/1", i, wr_en, count);
            end
            tick();
        end
        hold = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b1 || wr_data !== 16'h0101) begin
            failures++; $display("FAIL hold_release got=%0b/%h exp=1/0101", wr_en, wr_data);
        end
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL hold_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_reg;
        logic [15:0] exp_data;
        hold = 1'b1;
        for (int n = 0; n < 2; n++) begin
            in_valid = 1'b1; in_reg = 3'(n); in_data = 16'hC000 + 16'(n);
            tick();
        end
        hold = 1'b0;
        for (int j = 0; j < 12; j++) begin
            in_valid = 1'b1; in_reg = 3'(j + 2); in_data = 16'hC000 + 16'(j + 2);
            exp_reg = 3'(j); exp_data = 16'hC000 + 16'(j);
            #1;
            checks++; if (wr_en !== 1'b1 || wr_reg !== exp_reg || wr_data !== exp_data || count !== 3'd2) begin
                failures++; $display("FAIL b2b[%0d] got=%0b/%0d/%h/%0d exp=1/%0d/%h/2", j, wr_en, wr_reg, wr_data, count, exp_reg, exp_data);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int j = 12; j < 14; j++) begin
            exp_reg = 3'(j); exp_data = 16'hC000 + 16'(j);
            #1;
            checks++; if (wr_reg !== exp_reg || wr_data !== exp_data) begin
                failures++; $display("FAIL b2b_drain[%0d] got=%0d/%h exp=%0d/%h", j, wr_reg, wr_data, exp_reg, exp_data);
            end
            tick();
        end
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin
            failures++; $display("FAIL b2b_empty got=%0b/%0d exp=1/0", empty, count);
        end
    endtask

    task automatic test_reset_mid_drain();
        hold = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            in_valid = 1'b1; in_reg = 3'(n); in_data = 16'hD000 + 16'(n);
            tick();
        end
        in_valid = 1'b0; hold = 1'b0; lookup_reg = 3'd2;
        #1;
        checks++; if (wr_en !== 1'b1 || count !== 3'd3) begin
            failures++; $display("FAIL rstmid_pre got=%0b/%0d exp=1/3", wr_en, count);
        end
        rst = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            failures++; $display("FAIL rstmid_async got=%0b/%0d/%0b exp=0/0/1", wr_en, count, empty);
        end
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0000 || in_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_lookup got=%0b/%h/%0b exp=0/0000/1", lookup_hit, lookup_data, in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (wr_en !== 1'b0 || empty !== 1'b1) begin
                failures++; $display("FAIL rstmid_stale[%0d] got=%0b/%0b exp=0/1", i, wr_en, empty);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic        exp_hit;
        logic [15:0] exp_data;
`ifdef WBQ_INPUT_BYPASS_EN
        exp_hit = 1'b1; exp_data = 16'h00FF;
`else
        exp_hit = 1'b0; exp_data = 16'h0000;
`endif
        hold = 1'b0; lookup_reg = 3'd2;
        in_valid = 1'b1; in_reg = 3'd2; in_data = 16'h00FF;
        #1;
        checks++; if (lookup_hit !== exp_hit || lookup_data !== exp_data) begin
            failures++; $display("FAIL bypass_same_cycle got=%0b/%h exp=%0b/%h", lookup_hit, lookup_data, exp_hit, exp_data);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_data !== 16'h00FF) begin
            failures++; $display("FAIL bypass_next_cycle got=%0b/%h exp=1/00ff", lookup_hit, lookup_data);
        end
        tick();
        checks++; if (lookup_hit !== 1'b0 || empty !== 1'b1) begin
            failures++; $display("FAIL bypass_after got=%0b/%0b exp=0/1", lookup_hit, empty);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_full_hold();
        test_lookup_newest();
        test_hold_delay();
        test_back_to_back();
        test_reset_mid_drain();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
